// File: rtl/ysyx_22041071_ex_if.sv
// EX-stage bus: upstream operand/control handshake (valid4/ready4) and the
// EX/MEM pipeline register handshake (valid5/ready5).
interface ysyx_22041071_ex_if #(
    parameter int XLEN = 64
);
    logic            valid4;
    logic            ready4;
    logic [XLEN-1:0] PC4;
    logic [31:0]     Ins3;
    logic            Brch2;
    logic            MEM_W_en2;
    logic            WB_sel2;
    logic            reg_w_en2;
    logic [4:0]      ALU_ctrl2;
    logic [4:0]      rdest1;
    logic [XLEN-1:0] rt_data1;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [11:0]     BImm2;

    logic            valid5;
    logic            ready5;
    logic [XLEN-1:0] PC5;
    logic [31:0]     Ins4;
    logic            MEM_W_en3;
    logic            WB_sel3;
    logic            reg_w_en3;
    logic [4:0]      rdest2;
    logic [XLEN-1:0] rt_data2;
    logic [XLEN-1:0] result1;
    logic            Brch_taken;
    logic [XLEN-1:0] BrPC;

    modport master (
        output valid4, PC4, Ins3, Brch2, MEM_W_en2, WB_sel2, reg_w_en2,
               ALU_ctrl2, rdest1, rt_data1, src_a, src_b, BImm2, ready5,
        input  ready4, valid5, PC5, Ins4, MEM_W_en3, WB_sel3, reg_w_en3,
               rdest2, rt_data2, result1, Brch_taken, BrPC
    );

    modport slave (
        input  valid4, PC4, Ins3, Brch2, MEM_W_en2, WB_sel2, reg_w_en2,
               ALU_ctrl2, rdest1, rt_data1, src_a, src_b, BImm2, ready5,
        output ready4, valid5, PC5, Ins4, MEM_W_en3, WB_sel3, reg_w_en3,
               rdest2, rt_data2, result1, Brch_taken, BrPC
    );
endinterface

// File: rtl/ysyx_22041071_ex.sv
// RV64IM execute stage: single-cycle ALU and branch resolution, plus an
// iterative shift-add / restoring-divide engine that stalls upstream.
module ysyx_22041071_ex #(
    parameter int XLEN     = 64,
    parameter int MD_STEPS = 64
) (
    input logic               clk,
    input logic               reset,
    ysyx_22041071_ex_if.slave bus
);

    localparam int CW = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;

    localparam logic [4:0] OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3,  OP_SLTU  = 5'd4,  OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6,  OP_SRA   = 5'd7,  OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9,  OP_ADDW  = 5'd10, OP_SUBW  = 5'd11;
    localparam logic [4:0] OP_SLLW  = 5'd12, OP_SRLW  = 5'd13, OP_SRAW  = 5'd14;
    localparam logic [4:0] OP_MUL   = 5'd15, OP_MULW  = 5'd16, OP_DIV   = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18, OP_REM   = 5'd19, OP_REMU  = 5'd20;
    localparam logic [4:0] OP_DIVW  = 5'd21, OP_DIVUW = 5'd22, OP_REMW  = 5'd23;
    localparam logic [4:0] OP_REMUW = 5'd24, OP_PASSB = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    md_state_e       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic            mul_q, mul_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic            valid5_q, valid5_d, brch_taken_q, brch_taken_d;
    logic            mem_w_en3_q, mem_w_en3_d, wb_sel3_q, wb_sel3_d;
    logic            reg_w_en3_q, reg_w_en3_d;
    logic [XLEN-1:0] pc5_q, pc5_d, rt_data2_q, rt_data2_d;
    logic [XLEN-1:0] result1_q, result1_d, br_pc_q, br_pc_d;
    logic [31:0]     ins4_q, ins4_d;
    logic [4:0]      rdest2_q, rdest2_d;

    logic [XLEN-1:0] a, b, a_ext, b_ext, a_mag, b_mag;
    logic [4:0]      op;
    logic            is_md, md_mul, md_w, md_sgn, md_rem, sa, sb;
    logic            out_free, accept;

    assign a  = bus.src_a;
    assign b  = bus.src_b;
    assign op = bus.ALU_ctrl2;

    assign is_md  = (op >= OP_MUL) && (op <= OP_REMUW);
    assign md_mul = (op == OP_MUL) || (op == OP_MULW);
    assign md_w   = (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
                    (op == OP_REMW) || (op == OP_REMUW);
    assign md_sgn = md_mul || (op == OP_DIV) || (op == OP_REM) ||
                    (op == OP_DIVW) || (op == OP_REMW);
    assign md_rem = (op == OP_REM) || (op == OP_REMU) ||
                    (op == OP_REMW) || (op == OP_REMUW);

    always_comb begin
        a_ext = a;
        b_ext = b;
        if (md_w) begin
            a_ext = md_sgn ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]};
            b_ext = md_sgn ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]};
        end
    end

    assign sa    = md_sgn && a_ext[XLEN-1];
    assign sb    = md_sgn && b_ext[XLEN-1];
    assign a_mag = sa ? -a_ext : a_ext;
    assign b_mag = sb ? -b_ext : b_ext;

    assign out_free   = !valid5_q || bus.ready5;
    assign bus.ready4 = out_free && (!is_md || st_q == ST_DONE);
    assign accept     = bus.valid4 && bus.ready4;

    // Restoring divide: partial remainder shifts in the next dividend bit
    // from the top of mplier_q, which fills with quotient bits from below.
    logic [XLEN:0] div_r, div_diff;
    assign div_r    = {acc_q, mplier_q[XLEN-1]};
    assign div_diff = div_r - {1'b0, mcand_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            mul_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            mul_q     <= mul_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mul_d     = mul_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        unique case (st_q)
            ST_IDLE: begin
                if (bus.valid4 && is_md) begin
                    st_d      = ST_BUSY;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mul_d     = md_mul;
                    mcand_d   = md_mul ? a_mag : b_mag;
                    mplier_d  = md_mul ? b_mag : a_mag;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    dz_d      = (b_ext == '0);
                end
            end
            ST_BUSY: begin
                if (mul_q) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else if (!div_diff[XLEN]) begin
                    acc_d    = div_diff[XLEN-1:0];
                    mplier_d = {mplier_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d    = div_r[XLEN-1:0];
                    mplier_d = {mplier_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CW'(MD_STEPS - 1)) st_d = ST_DONE;
                else                            cnt_d = cnt_q + CW'(1);
            end
            ST_DONE: begin
                if (accept) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Zero divisor is the only case where the restoring quotient needs an
    // override; overflow and remainder signs fall out of the magnitude math.
    logic [XLEN-1:0] md_raw, md_res;
    always_comb begin
        if (mul_q)       md_raw = neg_q ? -acc_q : acc_q;
        else if (md_rem) md_raw = neg_rem_q ? -acc_q : acc_q;
        else if (dz_q)   md_raw = '1;
        else             md_raw = neg_q ? -mplier_q : mplier_q;
        md_res = md_w ? sext32(md_raw[31:0]) : md_raw;
    end

    logic [31:0]     w_res;
    logic [XLEN-1:0] alu_res;
    always_comb begin
        w_res   = '0;
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_SLL:   alu_res = a << b[5:0];
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:   alu_res = a ^ b;
            OP_SRL:   alu_res = a >> b[5:0];
            OP_SRA:   alu_res = $signed(a) >>> b[5:0];
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_ADDW:  begin w_res = a[31:0] + b[31:0];           alu_res = sext32(w_res); end
            OP_SUBW:  begin w_res = a[31:0] - b[31:0];           alu_res = sext32(w_res); end
            OP_SLLW:  begin w_res = a[31:0] << b[4:0];           alu_res = sext32(w_res); end
            OP_SRLW:  begin w_res = a[31:0] >> b[4:0];           alu_res = sext32(w_res); end
            OP_SRAW:  begin w_res = $signed(a[31:0]) >>> b[4:0]; alu_res = sext32(w_res); end
            OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: alu_res = md_res;
            OP_PASSB: alu_res = b;
            default:  alu_res = '0;
        endcase
    end

    logic cond;
    always_comb begin
        case (bus.Ins3[14:12])
            3'b000:  cond = (a == b);
            3'b001:  cond = (a != b);
            3'b100:  cond = $signed(a) < $signed(b);
            3'b101:  cond = !($signed(a) < $signed(b));
            3'b110:  cond = (a < b);
            3'b111:  cond = !(a < b);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        valid5_d     = valid5_q;
        pc5_d        = pc5_q;
        ins4_d       = ins4_q;
        mem_w_en3_d  = mem_w_en3_q;
        wb_sel3_d    = wb_sel3_q;
        reg_w_en3_d  = reg_w_en3_q;
        rdest2_d     = rdest2_q;
        rt_data2_d   = rt_data2_q;
        result1_d    = result1_q;
        brch_taken_d = brch_taken_q;
        br_pc_d      = br_pc_q;
        if (accept) begin
            valid5_d     = 1'b1;
            pc5_d        = bus.PC4;
            ins4_d       = bus.Ins3;
            mem_w_en3_d  = bus.MEM_W_en2;
            wb_sel3_d    = bus.WB_sel2;
            reg_w_en3_d  = bus.reg_w_en2;
            rdest2_d     = bus.rdest1;
            rt_data2_d   = bus.rt_data1;
            result1_d    = alu_res;
            brch_taken_d = bus.Brch2 && cond;
            br_pc_d      = bus.PC4 + {{(XLEN-13){bus.BImm2[11]}}, bus.BImm2, 1'b0};
        end else if (bus.ready5) begin
            valid5_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid5_q     <= 1'b0;
            pc5_q        <= '0;
            ins4_q       <= '0;
            mem_w_en3_q  <= 1'b0;
            wb_sel3_q    <= 1'b0;
            reg_w_en3_q  <= 1'b0;
            rdest2_q     <= '0;
            rt_data2_q   <= '0;
            result1_q    <= '0;
            brch_taken_q <= 1'b0;
            br_pc_q      <= '0;
        end else begin
            valid5_q     <= valid5_d;
            pc5_q        <= pc5_d;
            ins4_q       <= ins4_d;
            mem_w_en3_q  <= mem_w_en3_d;
            wb_sel3_q    <= wb_sel3_d;
            reg_w_en3_q  <= reg_w_en3_d;
            rdest2_q     <= rdest2_d;
            rt_data2_q   <= rt_data2_d;
            result1_q    <= result1_d;
            brch_taken_q <= brch_taken_d;
            br_pc_q      <= br_pc_d;
        end
    end

    assign bus.valid5     = valid5_q;
    assign bus.PC5        = pc5_q;
    assign bus.Ins4       = ins4_q;
    assign bus.MEM_W_en3  = mem_w_en3_q;
    assign bus.WB_sel3    = wb_sel3_q;
    assign bus.reg_w_en3  = reg_w_en3_q;
    assign bus.rdest2     = rdest2_q;
    assign bus.rt_data2   = rt_data2_q;
    assign bus.result1    = result1_q;
    assign bus.Brch_taken = brch_taken_q;
    assign bus.BrPC       = br_pc_q;

endmodule

// File: tb/tb_ysyx_22041071_ex.sv
// Bench for the execute stage: arithmetic reference model plus per-cycle
// compare of handshake and EX/MEM register contents, and directed vectors.
module tb_ysyx_22041071_ex;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22041071_ex_if #(.XLEN(64)) bus ();

    ysyx_22041071_ex #(.XLEN(64), .MD_STEPS(64)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic [31:0]        ua, ub;
        logic signed [31:0] wa, wb;
        logic [63:0]        min64;
        logic               ovf64, ovf32;
        sa = a; sb = b; ua = a[31:0]; ub = b[31:0]; wa = ua; wb = ub;
        min64 = 64'h8000_0000_0000_0000;
        ovf64 = (a == min64) && (b == '1);
        ovf32 = (ua == 32'h8000_0000) && (ub == '1);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[5:0];
            5'd3:  return (sa < sb) ? 64'd1 : 64'd0;
            5'd4:  return (a < b) ? 64'd1 : 64'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[5:0];
            5'd7:  return sa >>> b[5:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return sx(ua + ub);
            5'd11: return sx(ua - ub);
            5'd12: return sx(ua << b[4:0]);
            5'd13: return sx(ua >> b[4:0]);
            5'd14: return sx(wa >>> b[4:0]);
            5'd15: return a * b;
            5'd16: return sx(ua * ub);
            5'd17: begin if (b == 0) return '1; if (ovf64) return a; return sa / sb; end
            5'd18: begin if (b == 0) return '1; return a / b; end
            5'd19: begin if (b == 0) return a; if (ovf64) return 64'd0; return sa % sb; end
            5'd20: begin if (b == 0) return a; return a % b; end
            5'd21: begin if (ub == 0) return '1; if (ovf32) return sx(ua); return sx(wa / wb); end
            5'd22: begin if (ub == 0) return '1; return sx(ua / ub); end
            5'd23: begin if (ub == 0) return sx(ua); if (ovf32) return 64'd0; return sx(wa % wb); end
            5'd24: begin if (ub == 0) return sx(ua); return sx(ua % ub); end
            5'd25: return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic model_taken(input logic brch, input logic [2:0] f3,
                                         input logic [63:0] a, input logic [63:0] b);
        if (!brch) return 1'b0;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        mw, wbs, rw;
        logic [4:0]  rd;
        logic [63:0] rt;
        logic [63:0] res;
        logic        tk;
        logic [63:0] brpc;
    } rec_t;

    rec_t exp_rec, pend_rec;
    logic exp_v = 1'b0, pend = 1'b0, pend_drain = 1'b0, exp_r4;
    int   md_age = 0;

    function automatic logic op_is_md(input logic [4:0] op);
        return (op >= 5'd15) && (op <= 5'd24);
    endfunction

    // An MD op may only be accepted after 65 cycles of continuous presentation.
    always @(negedge clk) begin
        if (rst) begin
            exp_v  = 1'b0;
            pend   = 1'b0;
            md_age = 0;
            chk("valid5_in_reset", {63'd0, bus.valid5}, 64'd0);
        end else begin
            if (pend) begin
                exp_rec = pend_rec;
                exp_v   = 1'b1;
            end else if (pend_drain) begin
                exp_v = 1'b0;
            end
            exp_r4 = (!exp_v || bus.ready5) && (!op_is_md(bus.ALU_ctrl2) || md_age >= 65);
            chk("ready4", {63'd0, bus.ready4}, {63'd0, exp_r4});
            chk("valid5", {63'd0, bus.valid5}, {63'd0, exp_v});
            if (exp_v) begin
                chk("PC5",        bus.PC5, exp_rec.pc);
                chk("Ins4",       {32'd0, bus.Ins4}, {32'd0, exp_rec.ins});
                chk("ctrl3",      {61'd0, bus.MEM_W_en3, bus.WB_sel3, bus.reg_w_en3},
                                  {61'd0, exp_rec.mw, exp_rec.wbs, exp_rec.rw});
                chk("rdest2",     {59'd0, bus.rdest2}, {59'd0, exp_rec.rd});
                chk("rt_data2",   bus.rt_data2, exp_rec.rt);
                chk("result1",    bus.result1, exp_rec.res);
                chk("Brch_taken", {63'd0, bus.Brch_taken}, {63'd0, exp_rec.tk});
                chk("BrPC",       bus.BrPC, exp_rec.brpc);
            end
            pend       = bus.valid4 && exp_r4;
            pend_drain = bus.ready5;
            pend_rec.pc   = bus.PC4;
            pend_rec.ins  = bus.Ins3;
            pend_rec.mw   = bus.MEM_W_en2;
            pend_rec.wbs  = bus.WB_sel2;
            pend_rec.rw   = bus.reg_w_en2;
            pend_rec.rd   = bus.rdest1;
            pend_rec.rt   = bus.rt_data1;
            pend_rec.res  = model_alu(bus.ALU_ctrl2, bus.src_a, bus.src_b);
            pend_rec.tk   = model_taken(bus.Brch2, bus.Ins3[14:12], bus.src_a, bus.src_b);
            pend_rec.brpc = bus.PC4 + {{51{bus.BImm2[11]}}, bus.BImm2, 1'b0};
            if (bus.valid4 && op_is_md(bus.ALU_ctrl2)) md_age = pend ? 0 : md_age + 1;
            else                                        md_age = 0;
        end
    end

    task automatic drive(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic brch, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [63:0] pc);
        bus.ALU_ctrl2 = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.Brch2     = brch;
        bus.Ins3      = {17'd0, f3, 12'h063};
        bus.BImm2     = imm;
        bus.PC4       = pc;
        bus.rdest1    = op;
        bus.rt_data1  = a ^ b;
        bus.MEM_W_en2 = a[0];
        bus.WB_sel2   = b[0];
        bus.reg_w_en2 = a[1];
        bus.valid4    = 1'b1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic brch, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [63:0] pc, output int stall);
        logic got;
        got   = 1'b0;
        stall = 0;
        drive(op, a, b, brch, f3, imm, pc);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.ready4) begin
                got = 1'b1;
                break;
            end
            stall++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready4 got 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        bus.valid4 = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] expv);
        int st;
        issue(op, a, b, 1'b0, 3'd0, 12'd0, 64'h1000, st);
        chk(name, bus.result1, expv);
    endtask

    initial begin
        int st;
        bus.valid4 = 1'b0;
        bus.ready5 = 1'b1;
        drive(5'd0, 64'd0, 64'd0, 1'b0, 3'd0, 12'd0, 64'd0);
        bus.valid4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid5", {63'd0, bus.valid5}, 64'd0);
        chk("rst_result1", bus.result1, 64'd0);
        chk("rst_pc_brpc", bus.PC5 | bus.BrPC | bus.rt_data2, 64'd0);
        chk("rst_misc", {25'd0, bus.Ins4, bus.rdest2, bus.Brch_taken,
                         bus.MEM_W_en3, bus.WB_sel3, bus.reg_w_en3}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(5'd0, 64'd5, 64'd7, 1'b0, 3'd0, 12'd0, 64'h100, st);
        chk("add_result", bus.result1, 64'd12);
        chk("add_stall", st, 0);
        bus.ready5 = 1'b0;
        drive(5'd0, 64'd1, 64'd1, 1'b0, 3'd0, 12'd0, 64'h104);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready4", {63'd0, bus.ready4}, 64'd0);
            chk("bp_hold", bus.result1, 64'd12);
        end
        bus.ready5 = 1'b1;
        issue(5'd0, 64'd1, 64'd1, 1'b0, 3'd0, 12'd0, 64'h104, st);
        chk("bp_release", bus.result1, 64'd2);

        run_op("addw",  5'd10, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        run_op("subw",  5'd11, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sraw",  5'd14, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        run_op("slt",   5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        run_op("sltu",  5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        run_op("sra63", 5'd7, 64'h8000_0000_0000_0000, 64'h7F, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sllw31", 5'd12, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000);
        run_op("passb", 5'd25, 64'd9, 64'hDEAD, 64'hDEAD);
        run_op("badop", 5'd26, 64'd9, 64'd3, 64'd0);

        issue(5'd1, 64'd3, 64'd3, 1'b1, 3'b000, 12'h008, 64'h8000_0000, st);
        chk("beq_taken", {63'd0, bus.Brch_taken}, 64'd1);
        chk("beq_target", bus.BrPC, 64'h8000_0010);
        issue(5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 3'b110, 12'hFFC, 64'h8000_0000, st);
        chk("bltu_taken", {63'd0, bus.Brch_taken}, 64'd0);
        chk("bltu_target", bus.BrPC, 64'h7FFF_FFF8);
        issue(5'd1, 64'd3, 64'd3, 1'b0, 3'b000, 12'h008, 64'h200, st);
        chk("nobrch_taken", {63'd0, bus.Brch_taken}, 64'd0);
        issue(5'd1, 64'd3, 64'd3, 1'b1, 3'b010, 12'h008, 64'h200, st);
        chk("f3_010_taken", {63'd0, bus.Brch_taken}, 64'd0);

        issue(5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 3'd0, 12'd0, 64'h300, st);
        chk("mul_stall", st, 65);
        chk("mul_result", bus.result1, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("div_by0",  5'd17, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem_by0",  5'd19, 64'd100, 64'd0, 64'd100);
        run_op("div_ovf",  5'd17, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        run_op("rem_ovf",  5'd19, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_op("divw",     5'd21, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu",     5'd18, 64'd100, 64'd7, 64'd14);
        run_op("remu",     5'd20, 64'd100, 64'd7, 64'd2);
        run_op("remw",     5'd23, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulw",     5'd16, 64'h1_0000, 64'h1_0000, 64'd0);
        run_op("divuw",    5'd22, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remuw_by0", 5'd24, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005);
        run_op("divw_ovf", 5'd21, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);

        for (int i = 0; i < 6; i++) begin
            logic [63:0] x, y;
            x = 64'h0123_4567_89AB_CDEF << i;
            y = 64'hF0F0_0F0F_3C3C_C3C3 >> i;
            issue(5'(5 + (i % 5)), x, y, 1'b0, 3'd0, 12'd0, 64'h400 + 64'(i * 4), st);
            chk("b2b_stall", st, 0);
        end

        bus.ready5 = 1'b0;
        drive(5'd17, 64'd1000, 64'd3, 1'b0, 3'd0, 12'd0, 64'h500);
        repeat (31) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid5", {63'd0, bus.valid5}, 64'd0);
        chk("midrst_result1", bus.result1, 64'd0);
        repeat (2) @(negedge clk);
        bus.valid4 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ready5 = 1'b1;
        @(posedge clk);
        #1;
        issue(5'd0, 64'd20, 64'd22, 1'b0, 3'd0, 12'd0, 64'h600, st);
        chk("post_rst_stall", st, 0);
        chk("post_rst_add", bus.result1, 64'd42);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
